// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit seven-segment driver with blanking between digit slots,
// frame-coherent value commit, per-digit dark/dp control and leading-zero suppression.
module seven_seg_scan #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_en,
  output logic [6:0]            segments,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic                  frame_start
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  generate
    if (N_DIGITS < 1 || BLANK_CYCLES < 1 || BLANK_CYCLES >= DIGIT_CYCLES) begin : g_bad_params
      $error("seven_seg_scan: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {
    SLOT_BLANK,
    SLOT_DRIVE
  } slot_t;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] pend_value, com_value;
  logic [N_DIGITS-1:0]   pend_dp, com_dp, pend_blank, com_blank;

  slot_t               slot;
  logic                cnt_wrap, idx_wrap, frame_edge;
  logic [N_DIGITS-1:0] lz_dark;
  logic                chain;
  int unsigned         di;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank, cur_lz;
  logic [6:0]          seg_d;
  logic                dpn_d;
  logic [N_DIGITS-1:0] an_d;

  always_comb begin
    cnt_wrap   = (cnt == CW'(DIGIT_CYCLES - 1));
    idx_wrap   = (idx == IW'(N_DIGITS - 1));
    frame_edge = (cnt == '0) && (idx == '0);
    slot       = (cnt < CW'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_DRIVE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= idx_wrap ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // A load coinciding with the commit edge is committed directly, bypassing pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_value <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      com_value  <= '0;
      com_dp     <= '0;
      com_blank  <= '0;
    end else begin
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_blank <= blank_mask;
      end
      if (frame_edge) begin
        com_value <= load ? value      : pend_value;
        com_dp    <= load ? dp         : pend_dp;
        com_blank <= load ? blank_mask : pend_blank;
      end
    end
  end

  // Suppression walks down from the top digit; a zero digit showing its dp ends the run.
  always_comb begin
    lz_dark = '0;
    chain   = lz_en;
    di      = 0;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      di = N_DIGITS - 1 - k;
      if (chain && (di != 0) && (com_value[4*di +: 4] == 4'h0)) begin
        lz_dark[di] = 1'b1;
        if (com_dp[di] && !com_blank[di]) chain = 1'b0;
      end else begin
        chain = 1'b0;
      end
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    cur_lz    = 1'b0;
    an_d      = '1;
    for (int unsigned k = 0; k < N_DIGITS; k++) begin
      if (IW'(k) == idx) begin
        cur_nib   = com_value[4*k +: 4];
        cur_dp    = com_dp[k];
        cur_blank = com_blank[k];
        cur_lz    = lz_dark[k];
        if (slot == SLOT_DRIVE) an_d[k] = 1'b0;
      end
    end
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (slot == SLOT_DRIVE && !cur_blank) begin
      dpn_d = ~cur_dp;
      if (!cur_lz) seg_d = decode(cur_nib);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments    <= 7'h7F;
      dp_n        <= 1'b1;
      anode_n     <= '1;
      frame_start <= 1'b0;
    end else begin
      segments    <= seg_d;
      dp_n        <= dpn_d;
      anode_n     <= an_d;
      frame_start <= frame_edge;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: stimulus queues the expected contents of each
// upcoming frame, a monitor checks every cycle of each frame against the queue.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int DC = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * DC;
  localparam int NFRAMES = 8;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;
  localparam logic [6:0] SF = 7'b0111000;
  localparam logic [6:0] DK = 7'h7F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic [ND-1:0] dp;
  logic [ND-1:0] blank_mask;
  logic          lz_en;
  logic [6:0]    segments;
  logic          dp_n;
  logic [ND-1:0] anode_n;
  logic          frame_start;

  seven_seg_scan #(
    .N_DIGITS    (ND),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .dp         (dp),
    .blank_mask (blank_mask),
    .lz_en      (lz_en),
    .segments   (segments),
    .dp_n       (dp_n),
    .anode_n    (anode_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [27:0] segs;
    logic [3:0]  dpn;
  } frame_exp_t;

  typedef struct {
    bit          ld1;
    logic [15:0] v1;
    logic [3:0]  dp1;
    logic [3:0]  bm1;
    bit          ld2;
    logic [15:0] v2;
    bit          cl;
    logic [15:0] cv;
    bit          lz_next;
    frame_exp_t  nxt;
  } act_t;

  frame_exp_t sb[$];
  act_t       tbl[7];
  int         checks = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic frame_exp_t mk(input logic [6:0] d3, input logic [6:0] d2,
                                    input logic [6:0] d1, input logic [6:0] d0,
                                    input logic [3:0] dpn);
    frame_exp_t e;
    e.segs = {d3, d2, d1, d0};
    e.dpn  = dpn;
    return e;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{1, 16'h1B6F, 4'h0, 4'h0, 0, 16'h0000, 0, 16'h0000, 0, mk(S1, SB, S6, SF, 4'hF)};
    tbl[1] = '{1, 16'h1234, 4'h0, 4'h0, 1, 16'h0050, 0, 16'h0000, 1, mk(DK, DK, S5, S0, 4'hF)};
    tbl[2] = '{1, 16'h0000, 4'h0, 4'h0, 0, 16'h0000, 0, 16'h0000, 1, mk(DK, DK, DK, S0, 4'hF)};
    tbl[3] = '{1, 16'h0000, 4'b0100, 4'h0, 0, 16'h0000, 0, 16'h0000, 1, mk(DK, DK, S0, S0, 4'b1011)};
    tbl[4] = '{1, 16'h8888, 4'b0010, 4'b0010, 0, 16'h0000, 0, 16'h0000, 0, mk(S8, S8, DK, S8, 4'hF)};
    tbl[5] = '{1, 16'h5555, 4'h0, 4'h0, 0, 16'h0000, 1, 16'hABCD, 0, mk(SA, SB, SC, SD, 4'hF)};
    tbl[6] = '{0, 16'h0000, 4'h0, 4'h0, 0, 16'h0000, 0, 16'h0000, 0, mk(SA, SB, SC, SD, 4'hF)};

    rst_n = 1'b0;
    load = 1'b0;
    value = '0;
    dp = '0;
    blank_mask = '0;
    lz_en = 1'b0;
    sb.push_back(mk(S0, S0, S0, S0, 4'hF));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    fork
      begin : stimulus
        for (int k = 0; k < NFRAMES; k++) begin
          int n;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!frame_start && n < 100);
          load  = 1'b0;
          lz_en = (k == 0) ? 1'b0 : tbl[k-1].lz_next;
          if (k < NFRAMES - 1) begin
            sb.push_back(tbl[k].nxt);
            for (int o = 1; o < FRAME; o++) begin
              @(negedge clk);
              if (o == 10 && tbl[k].ld1) begin
                load = 1'b1; value = tbl[k].v1; dp = tbl[k].dp1; blank_mask = tbl[k].bm1;
              end else if (o == 12 && tbl[k].ld2) begin
                load = 1'b1; value = tbl[k].v2; dp = '0; blank_mask = '0;
              end else if (o == FRAME - 1 && tbl[k].cl) begin
                load = 1'b1; value = tbl[k].cv; dp = '0; blank_mask = '0;
              end else begin
                load = 1'b0;
              end
            end
          end
        end
      end

      begin : monitor
        for (int f = 0; f < NFRAMES; f++) begin
          int n;
          frame_exp_t e;
          logic [3:0] an_e;
          logic [12:0] req;
          n = 0;
          do begin
            @(negedge clk);
            n++;
          end while (!frame_start && n < 100);
          check($sformatf("frame%0d_start_seen", f), {31'b0, frame_start}, 32'd1);
          if (!frame_start) break;
          if (f > 0) check($sformatf("frame%0d_period", f), n, 32'd1);
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL frame%0d_scoreboard actual=empty required=entry", f);
            break;
          end
          e = sb.pop_front();
          for (int o = 0; o < FRAME; o++) begin
            int s;
            int c;
            if (o > 0) @(negedge clk);
            s = o / DC;
            c = o % DC;
            an_e = 4'b0001 << s;
            an_e = ~an_e;
            if (c < BC) req = {(o == 0), 4'hF, 7'h7F, 1'b1};
            else        req = {1'b0, an_e, e.segs[7*s +: 7], e.dpn[s]};
            check($sformatf("frame%0d_o%0d", f, o), {19'b0, frame_start, anode_n, segments, dp_n},
                  {19'b0, req});
          end
        end
      end
    join

    begin : reset_test
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!frame_start && n < 100);
      repeat (20) @(negedge clk);
      check("pre_reset_digit2", {28'b0, anode_n}, {28'b0, 4'b1011});
      #1 rst_n = 1'b0;
      #1 check("reset_async_dark", {19'b0, anode_n, segments, dp_n, frame_start},
               {19'b0, 4'hF, 7'h7F, 1'b1, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_frame_start", {27'b0, frame_start, anode_n}, {27'b0, 1'b1, 4'hF});
      repeat (2) @(negedge clk);
      check("restart_digit0", {20'b0, anode_n, segments, dp_n}, {20'b0, 4'b1110, S0, 1'b1});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
